// File: rtl/mem_interconnect.sv
// Registered single-master to NUM_SLAVES-slave memory interconnect with address
// decode, per-slave ready handshake, timeout watchdog and sticky error capture.
module mem_interconnect #(
  parameter int          NUM_SLAVES = 4,
  parameter int          SEL_LSB    = 22,
  parameter int          SEL_BITS   = 2,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               cpu_addr_i,
  input  logic                      cpu_rstrb_i,
  input  logic [3:0]                cpu_wmask_i,
  input  logic [31:0]               cpu_wdata_i,
  output logic [31:0]               cpu_rdata_o,
  output logic                      cpu_ready_o,
  output logic [31:0]               s_addr_o,
  output logic [31:0]               s_wdata_o,
  output logic [NUM_SLAVES-1:0]     s_rstrb_o,
  output logic [4*NUM_SLAVES-1:0]   s_wmask_o,
  input  logic [32*NUM_SLAVES-1:0]  s_rdata_i,
  input  logic [NUM_SLAVES-1:0]     s_ready_i,
  output logic                      bus_err_o,
  output logic [31:0]               err_addr_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT);
  localparam logic [SEL_BITS:0] NUM_SL   = (SEL_BITS + 1)'(NUM_SLAVES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [31:0]             addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic                    is_wr_q, is_wr_d;
  logic [SEL_BITS-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic [NUM_SLAVES-1:0]   rstrb_q, rstrb_d;
  logic [4*NUM_SLAVES-1:0] wmask_q, wmask_d;
  logic                    err_q, err_d;
  logic [31:0]             err_addr_q, err_addr_d;

  logic [SEL_BITS-1:0]     req_idx_s;
  logic [NUM_SLAVES-1:0]   req_dec_s;
  logic                    req_unmapped_s;
  logic                    req_is_wr_s;
  logic                    accept_s;
  logic                    sel_ready_s;
  logic [31:0]             sel_rdata_s;
  logic [CNT_W-1:0]        cnt_inc_s;

  assign req_idx_s      = cpu_addr_i[SEL_LSB +: SEL_BITS];
  assign req_unmapped_s = ({1'b0, req_idx_s} >= NUM_SL);
  assign req_is_wr_s    = (cpu_wmask_i != 4'b0000);
  // A request seen while the completion pulse is out belongs to no transaction.
  assign accept_s       = !ready_q && (cpu_rstrb_i || req_is_wr_s);
  assign cnt_inc_s      = cnt_q + CNT_W'(1);

  always_comb begin
    req_dec_s   = '0;
    sel_ready_s = 1'b0;
    sel_rdata_s = 32'h0000_0000;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      req_dec_s[i] = (req_idx_s == SEL_BITS'(i));
      sel_ready_s  = sel_ready_s | (s_ready_i[i] & (idx_q == SEL_BITS'(i)));
      sel_rdata_s  = sel_rdata_s | (s_rdata_i[32*i +: 32] & {32{idx_q == SEL_BITS'(i)}});
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    rstrb_d    = '0;
    wmask_d    = '0;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          addr_d  = cpu_addr_i;
          wdata_d = cpu_wdata_i;
          is_wr_d = req_is_wr_s;
          idx_d   = req_idx_s;
          cnt_d   = {CNT_W{1'b0}};
          if (req_unmapped_s) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
            if (!req_is_wr_s) begin
              rdata_d = ERR_RDATA;
            end else begin
              rdata_d = rdata_q;
            end
            if (!err_q) begin
              err_addr_d = cpu_addr_i;
            end else begin
              err_addr_d = err_addr_q;
            end
          end else begin
            state_d = ST_REQ;
            for (int i = 0; i < NUM_SLAVES; i++) begin
              rstrb_d[i]       = req_dec_s[i] & !req_is_wr_s;
              wmask_d[4*i +: 4] = cpu_wmask_i & {4{req_dec_s[i]}};
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ, ST_WAIT: begin
        if (sel_ready_s) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
          if (!is_wr_q) begin
            rdata_d = sel_rdata_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (state_q == ST_REQ) begin
          state_d = ST_WAIT;
        end else if (cnt_inc_s == CNT_LAST) begin
          // Watchdog expired: answer the master with an error instead of hanging.
          ready_d = 1'b1;
          state_d = ST_IDLE;
          err_d   = 1'b1;
          if (!is_wr_q) begin
            rdata_d = ERR_RDATA;
          end else begin
            rdata_d = rdata_q;
          end
          if (!err_q) begin
            err_addr_d = addr_q;
          end else begin
            err_addr_d = err_addr_q;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      wdata_q    <= 32'h0000_0000;
      is_wr_q    <= 1'b0;
      idx_q      <= {SEL_BITS{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      rdata_q    <= 32'h0000_0000;
      ready_q    <= 1'b0;
      rstrb_q    <= '0;
      wmask_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      rstrb_q    <= rstrb_d;
      wmask_q    <= wmask_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign cpu_rdata_o = rdata_q;
  assign cpu_ready_o = ready_q;
  assign s_addr_o    = addr_q;
  assign s_wdata_o   = wdata_q;
  assign s_rstrb_o   = rstrb_q;
  assign s_wmask_o   = wmask_q;
  assign bus_err_o   = err_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_mem_interconnect.sv
// Directed plus random bench for mem_interconnect (3 slaves, TIMEOUT=4) against a
// cycle-count reference model of the transaction rules.
module tb_mem_interconnect;

  localparam int          NS  = 3;
  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   cpu_addr_i, cpu_wdata_i;
  logic          cpu_rstrb_i;
  logic [3:0]    cpu_wmask_i;
  logic [31:0]   cpu_rdata_o, s_addr_o, s_wdata_o, err_addr_o;
  logic          cpu_ready_o, bus_err_o;
  logic [NS-1:0] s_rstrb_o, s_ready_i;
  logic [4*NS-1:0]  s_wmask_o;
  logic [32*NS-1:0] s_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rdata_m = 32'h0;
  logic        berr_m  = 1'b0;
  logic [31:0] eaddr_m = 32'h0;

  mem_interconnect #(
    .NUM_SLAVES(NS), .SEL_LSB(22), .SEL_BITS(2), .TIMEOUT(TO), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_addr_i(cpu_addr_i), .cpu_rstrb_i(cpu_rstrb_i), .cpu_wmask_i(cpu_wmask_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rstrb_o(s_rstrb_o),
    .s_wmask_o(s_wmask_o), .s_rdata_i(s_rdata_i), .s_ready_i(s_ready_i),
    .bus_err_o(bus_err_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdata"},  cpu_rdata_o, 32'h0);
    check({tag, "_ready"},  32'(cpu_ready_o), 32'h0);
    check({tag, "_saddr"},  s_addr_o, 32'h0);
    check({tag, "_swdata"}, s_wdata_o, 32'h0);
    check({tag, "_rstrb"},  32'(s_rstrb_o), 32'h0);
    check({tag, "_wmask"},  32'(s_wmask_o), 32'h0);
    check({tag, "_berr"},   32'(bus_err_o), 32'h0);
    check({tag, "_eaddr"},  err_addr_o, 32'h0);
  endtask

  // Cycle c counts from the cycle the request is presented; the target answers in cycle 1+d.
  task automatic drive_ready(input int c, input int idx, input bit unm, input int d);
    s_ready_i = NS'($urandom);
    if (!unm && c >= 1) s_ready_i[idx] = (c == 1 + d);
  endtask

  task automatic run_txn(input string tag, input logic [31:0] addr, input logic rd,
                         input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] sdata,
                         input int d, input bit hold);
    int idx, tdone;
    bit is_wr, unm, err;
    logic [32*NS-1:0] rdat;
    logic [31:0] rstrb_e, wmask_e;
    idx   = int'(addr[23:22]);
    is_wr = (wm != 4'h0);
    unm   = (idx >= NS);
    err   = unm || (d > TO);
    tdone = unm ? 1 : ((d <= TO) ? 2 + d : 2 + TO);
    rdat  = {$urandom, $urandom, $urandom};
    if (!unm) rdat[32*idx +: 32] = sdata;
    s_rdata_i   = rdat;
    cpu_addr_i  = addr;
    cpu_rstrb_i = rd;
    cpu_wmask_i = wm;
    cpu_wdata_i = wd;
    drive_ready(0, idx, unm, d);
    for (int t = 0; t <= tdone; t++) begin
      @(negedge clk);
      rstrb_e = 32'h0;
      wmask_e = 32'h0;
      if (t == 1 && !unm) begin
        rstrb_e = is_wr ? 32'h0 : (32'h1 << idx);
        wmask_e = is_wr ? (32'(wm) << (4 * idx)) : 32'h0;
        check({tag, "_saddr"},  s_addr_o, addr);
        check({tag, "_swdata"}, s_wdata_o, wd);
      end
      check({tag, "_rstrb"}, 32'(s_rstrb_o), rstrb_e);
      check({tag, "_wmask"}, 32'(s_wmask_o), wmask_e);
      check({tag, "_ready"}, 32'(cpu_ready_o), (t == tdone) ? 32'h1 : 32'h0);
      if (t == tdone) begin
        if (!is_wr) rdata_m = err ? ERR : rdat[32*idx +: 32];
        if (err) begin
          if (!berr_m) eaddr_m = addr;
          berr_m = 1'b1;
        end
        check({tag, "_rdata"}, cpu_rdata_o, rdata_m);
        check({tag, "_berr"},  32'(bus_err_o), 32'(berr_m));
        check({tag, "_eaddr"}, err_addr_o, eaddr_m);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
        cpu_rstrb_i = 1'b0;
        cpu_wmask_i = 4'h0;
      end
      drive_ready(t + 1, idx, unm, d);
    end
    cpu_rstrb_i = 1'b0;
    cpu_wmask_i = 4'h0;
  endtask

  initial begin
    int sel, kind, dly;
    logic [31:0] a;
    rst = 1'b1;
    cpu_addr_i = 32'h0; cpu_rstrb_i = 1'b0; cpu_wmask_i = 4'h0; cpu_wdata_i = 32'h0;
    s_rdata_i = '0; s_ready_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset("reset");
    @(posedge clk);
    #1;

    run_txn("rd_s1",   32'h0040_0010, 1'b1, 4'h0, 32'h0, 32'h1234_5678, 0, 1'b0);
    run_txn("wr_s0",   32'h0000_0100, 1'b0, 4'b0011, 32'hAABB_CCDD, 32'h0, 3, 1'b0);
    run_txn("unm_rd",  32'h00C0_0000, 1'b1, 4'h0, 32'h0, 32'h0, 0, 1'b0);
    run_txn("unm_wr2", 32'h00C0_0004, 1'b0, 4'hF, 32'h5555_AAAA, 32'h0, 0, 1'b0);
    run_txn("tmo_s2",  32'h0080_0000, 1'b1, 4'h0, 32'h0, 32'h0, 99, 1'b0);
    run_txn("both_s1", 32'h0040_0020, 1'b1, 4'hF, 32'h0BAD_F00D, 32'h0, 2, 1'b1);

    // Reset during WAIT with the sticky error already set.
    cpu_addr_i = 32'h0080_0000; cpu_rstrb_i = 1'b1; cpu_wmask_i = 4'h0; s_ready_i = '0;
    @(posedge clk); #1 cpu_rstrb_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_wait_ready", 32'(cpu_ready_o), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");
    rdata_m = 32'h0; berr_m = 1'b0; eaddr_m = 32'h0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_no_pulse", 32'(cpu_ready_o), 32'h0);
    @(posedge clk); #1;
    run_txn("rd_after_rst", 32'h0040_0000, 1'b1, 4'h0, 32'h0, 32'hCAFE_0001, 1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(3, 0);
      kind = $urandom_range(2, 0);
      case ($urandom_range(4, 0))
        0: dly = 0;
        1: dly = 1;
        2: dly = 2;
        3: dly = 3;
        default: dly = 99;
      endcase
      a = $urandom;
      a[23:22] = 2'(sel);
      run_txn("rand", a, (kind != 1), (kind == 0) ? 4'h0 : 4'($urandom_range(15, 1)),
              $urandom, $urandom, dly, $urandom_range(1, 0) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
